// File: rtl/pcie_tx_drain.sv
// Drains committed packets from a 64-bit TX FIFO into the PCIe core AXI-Stream port.
// Handles forced-tlast tails, oversize truncation and per-packet accounting.
module pcie_tx_drain #(
  parameter int PKT_CNT_W  = 8,
  parameter int BUF_AV_MIN = 1,
  parameter int MAX_BEATS  = 34
) (
  input  logic                 pcie_clk,
  input  logic                 pcie_rst,
  input  logic                 pkt_commit,
  input  logic [77:0]          dout,
  input  logic                 empty,
  output logic                 rd_en,
  input  logic [5:0]           tx_buf_av,
  output logic                 s_axis_tx_tvalid,
  input  logic                 s_axis_tx_tready,
  output logic [63:0]          s_axis_tx_tdata,
  output logic [7:0]           s_axis_tx_tkeep,
  output logic                 s_axis_tx_tlast,
  output logic [3:0]           s_axis_tx_tuser,
  output logic [31:0]          tx_pkt_cnt,
  output logic [15:0]          tx_dsc_cnt,
  output logic                 cnt_ovf
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [5:0] AV_MIN = 6'(BUF_AV_MIN);
  localparam logic [BW-1:0] LAST_IDX = BW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DISCARD} state_t;

  state_t state_q, state_d;

  logic                 f_valid, f_last;
  logic [7:0]           f_keep;
  logic [63:0]          f_data;
  logic                 unused_tuser;

  assign f_valid      = dout[77];
  assign f_last       = dout[76];
  assign f_keep       = dout[75:68];
  assign f_data       = dout[67:4];
  assign unused_tuser = ^dout[3:0];

  logic                 tvalid_q, tvalid_d;
  logic [63:0]          tdata_q, tdata_d;
  logic [7:0]           tkeep_q, tkeep_d;
  logic                 tlast_q, tlast_d;
  logic [3:0]           tuser_q, tuser_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          tx_pkt_q, tx_pkt_d;
  logic [15:0]          tx_dsc_q, tx_dsc_d;

  logic out_free, trunc, start, hs_last;

  assign out_free = !tvalid_q || s_axis_tx_tready;
  assign trunc    = f_valid && !f_last && (beat_q == LAST_IDX);
  assign start    = (pkt_cnt_q != '0) && !empty &&
                    (tx_buf_av >= AV_MIN) && out_free;
  assign hs_last  = tvalid_q && s_axis_tx_tready && tlast_q;

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (rd_en) begin
                 if (f_last)     state_d = IDLE;
                 else if (trunc) state_d = DISCARD;
               end
      DISCARD: if (rd_en && f_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    unique case (state_q)
      STREAM:  rd_en = !empty && out_free;
      DISCARD: rd_en = !empty;
      default: rd_en = 1'b0;
    endcase
    if (pcie_rst) rd_en = 1'b0;
  end

  always_comb begin
    tvalid_d = tvalid_q && !s_axis_tx_tready;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    beat_d   = (state_q == STREAM) ? beat_q : '0;
    if (state_q == STREAM && rd_en) begin
      if (f_valid) begin
        tvalid_d = 1'b1;
        tdata_d  = f_data;
        tlast_d  = f_last || trunc;
        tuser_d  = {trunc, 3'b000};
        tkeep_d  = (f_last && f_keep[7:4] == 4'h0) ? 8'h0F : 8'hFF;
        beat_d   = beat_q + BW'(1);
      end else if (f_last) begin
        tvalid_d = 1'b1;
        tdata_d  = '0;
        tlast_d  = 1'b1;
        tuser_d  = 4'b1000;
        tkeep_d  = 8'hFF;
      end
    end
  end

  // Commit and tlast-pop in the same cycle cancel out.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    ovf_d     = ovf_q;
    if (pkt_commit && !(rd_en && f_last)) begin
      if (&pkt_cnt_q) ovf_d = 1'b1;
      else            pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
    end else if (!pkt_commit && rd_en && f_last && pkt_cnt_q != '0) begin
      pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
    end
    tx_pkt_d = hs_last ? tx_pkt_q + 32'd1 : tx_pkt_q;
    tx_dsc_d = (hs_last && tuser_q[3]) ? tx_dsc_q + 16'd1 : tx_dsc_q;
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tuser_q   <= '0;
      beat_q    <= '0;
      pkt_cnt_q <= '0;
      ovf_q     <= 1'b0;
      tx_pkt_q  <= '0;
      tx_dsc_q  <= '0;
    end else begin
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
      beat_q    <= beat_d;
      pkt_cnt_q <= pkt_cnt_d;
      ovf_q     <= ovf_d;
      tx_pkt_q  <= tx_pkt_d;
      tx_dsc_q  <= tx_dsc_d;
    end
  end

  assign s_axis_tx_tvalid = tvalid_q;
  assign s_axis_tx_tdata  = tdata_q;
  assign s_axis_tx_tkeep  = tkeep_q;
  assign s_axis_tx_tlast  = tlast_q;
  assign s_axis_tx_tuser  = tuser_q;
  assign tx_pkt_cnt       = tx_pkt_q;
  assign tx_dsc_cnt       = tx_dsc_q;
  assign cnt_ovf          = ovf_q;

endmodule

// File: tb/tb_pcie_tx_drain.sv
// Bench for pcie_tx_drain: FIFO model, randomized sink, packet-level reference.
// Expected beats are derived per packet from the drain rules.
module tb_pcie_tx_drain;

  localparam int MAXB = 34;

  logic        clk = 1'b0;
  logic        pcie_rst;
  logic        pkt_commit;
  logic [77:0] dout;
  logic        empty;
  logic        rd_en;
  logic [5:0]  tx_buf_av;
  logic        tvalid, tready, tlast;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [3:0]  tuser;
  logic [31:0] tx_pkt_cnt;
  logic [15:0] tx_dsc_cnt;
  logic        cnt_ovf;

  always #5 clk = ~clk;

  pcie_tx_drain #(.PKT_CNT_W(8), .BUF_AV_MIN(1), .MAX_BEATS(MAXB)) dut (
    .pcie_clk(clk), .pcie_rst(pcie_rst), .pkt_commit(pkt_commit),
    .dout(dout), .empty(empty), .rd_en(rd_en), .tx_buf_av(tx_buf_av),
    .s_axis_tx_tvalid(tvalid), .s_axis_tx_tready(tready),
    .s_axis_tx_tdata(tdata), .s_axis_tx_tkeep(tkeep),
    .s_axis_tx_tlast(tlast), .s_axis_tx_tuser(tuser),
    .tx_pkt_cnt(tx_pkt_cnt), .tx_dsc_cnt(tx_dsc_cnt), .cnt_ovf(cnt_ovf));

  // FIFO model, first-word-fall-through
  logic [77:0] mem [1024];
  logic [9:0]  wr_ptr = '0;
  logic [9:0]  rd_ptr = '0;
  assign dout  = mem[rd_ptr];
  assign empty = (rd_ptr == wr_ptr);
  always @(posedge clk) if (rd_en && !empty) rd_ptr <= rd_ptr + 10'd1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pkt  = 0;
  int exp_dsc  = 0;
  int rdy_mode = 0;
  int cyc      = 0;

  logic [77:0] pkt_q[$];
  logic [76:0] exp_q[$];
  logic [76:0] rx_q[$];
  int          rx_cyc[$];

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [77:0] mk(input logic v, input logic l,
                                     input logic [7:0] k, input logic [63:0] d);
    return {v, l, k, d, 4'h0};
  endfunction

  task automatic push(input logic [77:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 10'd1;
    pkt_q.push_back(b);
  endtask

  // Reference: turn one FIFO packet into the beats the core should see.
  task automatic model_pkt();
    int  n = 0;
    bit  disc = 0;
    foreach (pkt_q[i]) begin
      logic        v, l;
      logic [7:0]  k;
      logic [63:0] d;
      v = pkt_q[i][77];
      l = pkt_q[i][76];
      k = pkt_q[i][75:68];
      d = pkt_q[i][67:4];
      if (disc) continue;
      if (v) begin
        n++;
        if (l) begin
          exp_q.push_back({d, (k[7:4] == 4'h0) ? 8'h0F : 8'hFF, 1'b1, 4'h0});
          exp_pkt++;
        end else if (n == MAXB) begin
          exp_q.push_back({d, 8'hFF, 1'b1, 4'h8});
          exp_pkt++; exp_dsc++; disc = 1;
        end else begin
          exp_q.push_back({d, 8'hFF, 1'b0, 4'h0});
        end
      end else if (l) begin
        exp_q.push_back({64'h0, 8'hFF, 1'b1, 4'h8});
        exp_pkt++; exp_dsc++; disc = 1;
      end
    end
    pkt_q.delete();
  endtask

  task automatic commit();
    @(negedge clk) pkt_commit = 1'b1;
    @(negedge clk) pkt_commit = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int c = 0;
    while (!(rx_q.size() >= exp_q.size() && empty) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_timeout"}, c < 3000, 1'b1);
    repeat (4) @(negedge clk);
    check({tag, "_nbeats"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), rx_q[i], exp_q[i]);
    check({tag, "_tx_pkt_cnt"}, tx_pkt_cnt, exp_pkt);
    check({tag, "_tx_dsc_cnt"}, tx_dsc_cnt, exp_dsc);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_tvalid"}, tvalid, 1'b0);
    check({tag, "_tdata"}, tdata, 64'h0);
    check({tag, "_tkeep"}, tkeep, 8'h0);
    check({tag, "_tlast"}, tlast, 1'b0);
    check({tag, "_tuser"}, tuser, 4'h0);
    check({tag, "_tx_pkt_cnt"}, tx_pkt_cnt, 32'h0);
    check({tag, "_tx_dsc_cnt"}, tx_dsc_cnt, 16'h0);
    check({tag, "_cnt_ovf"}, cnt_ovf, 1'b0);
    check({tag, "_pkt_cnt"}, dut.pkt_cnt_q, 8'h0);
  endtask

  // Sink: drives tready, records handshakes, checks hold-while-stalled.
  initial begin
    logic        prev_stall;
    logic [76:0] prev_out, cur;
    prev_stall = 1'b0;
    prev_out   = '0;
    tready     = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {tdata, tkeep, tlast, tuser};
      if (pcie_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_stable", cur, prev_out);
        case (rdy_mode)
          0:       tready = 1'b1;
          1:       tready = ~tready;
          default: tready = 1'($urandom_range(0, 1));
        endcase
        if (tvalid && tready) begin
          rx_q.push_back(cur);
          rx_cyc.push_back(cyc);
        end
        prev_stall = tvalid && !tready;
        prev_out   = cur;
      end
    end
  end

  initial begin
    int cnt_rd;
    bit seen;
    pcie_rst   = 1'b1;
    pkt_commit = 1'b0;
    tx_buf_av  = 6'd8;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    pcie_rst = 1'b0;
    @(negedge clk);

    // 3-beat packet, short last keep, sink always ready
    rx_cyc.delete();
    push(mk(1, 0, 8'hFF, 64'h1111_0000_0000_0001));
    push(mk(1, 0, 8'hFF, 64'h1111_0000_0000_0002));
    push(mk(1, 1, 8'h0F, 64'h1111_0000_0000_0003));
    model_pkt();
    commit();
    wait_drain("p3");
    check("p3_back2back", rx_cyc[2] - rx_cyc[0], 2);
    check("p3_pkt_cnt", dut.pkt_cnt_q, 8'h0);

    // 5-beat packet with toggling tready
    rdy_mode = 1;
    for (int i = 0; i < 5; i++)
      push(mk(1, i == 4, 8'hFF, 64'hA5A5_0000_0000_0000 + 64'(i)));
    model_pkt();
    commit();
    wait_drain("p5tog");

    // valid beat then forced tail
    rdy_mode = 0;
    push(mk(1, 0, 8'hFF, 64'hDEAD_BEEF_0000_0001));
    push(mk(0, 1, 8'h00, 64'h0));
    model_pkt();
    commit();
    wait_drain("tail");

    // oversize packet then an intact one
    for (int i = 0; i < 40; i++)
      push(mk(1, i == 39, 8'hFF, {32'hB16B_00B5, 32'(i)}));
    model_pkt();
    commit();
    for (int i = 0; i < 3; i++)
      push(mk(1, i == 2, 8'hFF, {32'hC0DE_0000, 32'(i)}));
    model_pkt();
    commit();
    wait_drain("trunc");

    // commit coinciding with a tlast pop
    push(mk(1, 0, 8'hFF, 64'h0101));
    push(mk(1, 1, 8'hFF, 64'h0102));
    model_pkt();
    commit();
    for (int i = 0; i < 3; i++)
      push(mk(1, i == 2, 8'hFF, 64'h0201 + 64'(i)));
    model_pkt();
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (rd_en && dout[76]) seen = 1;
    end
    check("coincide_seen", seen, 1'b1);
    pkt_commit = 1'b1;
    @(negedge clk);
    pkt_commit = 1'b0;
    check("coincide_pkt_cnt", dut.pkt_cnt_q, 8'h1);
    wait_drain("coincide");

    // no buffers available: hold off
    tx_buf_av = 6'd0;
    push(mk(1, 0, 8'hFF, 64'h0301));
    push(mk(1, 1, 8'hF0, 64'h0302));
    model_pkt();
    commit();
    cnt_rd = 0;
    repeat (12) begin
      @(negedge clk);
      if (rd_en) cnt_rd++;
    end
    check("bufav0_rd_en", cnt_rd, 0);
    tx_buf_av = 6'd1;
    wait_drain("bufav1");

    // randomized packets, two in flight at a time
    rdy_mode = 2;
    for (int p = 0; p < 8; p++) begin
      tx_buf_av = 6'($urandom_range(1, 63));
      for (int q = 0; q < 2; q++) begin
        int len;
        len = $urandom_range(1, 45);
        for (int i = 0; i < len; i++) begin
          logic [63:0] d;
          d = {$urandom, $urandom};
          if (i == len - 1) begin
            case ($urandom_range(0, 4))
              0:       push(mk(0, 1, 8'h00, 64'h0));
              1:       push(mk(1, 1, 8'h0F, d));
              2:       push(mk(1, 1, 8'h01, d));
              3:       push(mk(1, 1, 8'hF0, d));
              default: push(mk(1, 1, 8'hFF, d));
            endcase
          end else if ($urandom_range(0, 9) == 0) begin
            push(mk(0, 0, 8'hFF, d));
          end else begin
            push(mk(1, 0, 8'hFF, d));
          end
        end
        model_pkt();
        commit();
      end
      wait_drain($sformatf("rnd%0d", p));
    end
    rdy_mode = 0;

    // counter saturation, then reset
    check("pre_ovf_pkt_cnt", dut.pkt_cnt_q, 8'h0);
    repeat (256) commit();
    @(negedge clk);
    check("ovf_pkt_cnt", dut.pkt_cnt_q, 8'hFF);
    check("ovf_flag", cnt_ovf, 1'b1);
    check("ovf_no_rd", rd_en, 1'b0);
    pcie_rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("rst1");
    pcie_rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
